tt_um_johnson_checker: RTL and testbench

TT_UM_JOHNSON_CHECKER -- requirements
Module: tt_um_johnson_checker

---
 rtl/johnson_pkg.sv | 33 +++
 rtl/tt_um_johnson_checker_if.sv | 13 +
 rtl/johnson_decode.sv | 20 ++
 rtl/tt_um_johnson_checker.sv | 123 ++++++++++++
 tb/tb_tt_um_johnson_checker.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/johnson_pkg.sv
// Shared constants, FSM state type and code table for the Johnson checker.
// Build option: JOHNSON_CHK_ERRCNT_EN adds the saturating error counter.
package johnson_pkg;

    localparam int JOHNSON_WIDTH  = 8;
    localparam int JOHNSON_STATES = 16;
    localparam int IDX_W          = 4;

    localparam int UO_INDEX_LSB = 0;
    localparam int UO_VALID     = 4;
    localparam int UO_LOCKED    = 5;
    localparam int UO_PULSE     = 6;
    localparam int UO_STICKY    = 7;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK1 = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // Fill from the bottom for 0..8, then drain from the bottom.
    function automatic logic [JOHNSON_WIDTH-1:0] johnson_code(
        input logic [IDX_W-1:0] k
    );
        logic [JOHNSON_WIDTH-1:0] ones;
        ones = '1;
        if (k <= 4'd8)
            return ~(ones << k);
        else
            return ones << (k - 4'd8);
    endfunction

endpackage

// File: rtl/tt_um_johnson_checker_if.sv
// Code/decode bundle between a code source and the Johnson decoder.
// master: drives code, reads index/valid; slave: the decoder side.
interface tt_um_johnson_checker_if;
    import johnson_pkg::*;

    logic [JOHNSON_WIDTH-1:0] code;
    logic [IDX_W-1:0]         index;
    logic                     valid;

    modport master (output code, input index, input valid);
    modport slave  (input code, output index, output valid);

endinterface

// File: rtl/johnson_decode.sv
// Combinational Johnson code to index/valid decoder.
// Ports: bus (slave) - code in, index/valid out; invalid gives index 0.
module johnson_decode
    import johnson_pkg::*;
(
    tt_um_johnson_checker_if.slave bus
);

    always_comb begin
        bus.index = '0;
        bus.valid = 1'b0;
        for (int k = 0; k < JOHNSON_STATES; k++) begin
            if (bus.code == johnson_code(IDX_W'(k))) begin
                bus.valid = 1'b1;
                bus.index = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/tt_um_johnson_checker.sv
// Johnson sequence checker: decodes ui_in, locks on a rising sequence,
// flags breaks while locked. Ports: ui_in code, uio_in[0] sample_en,
// uo_out {sticky,pulse,locked,valid,index[3:0]}, uio_out err_cnt.
// Build option: JOHNSON_CHK_ERRCNT_EN enables err_cnt and uio_oe=8'h0F.
module tt_um_johnson_checker
    import johnson_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    tt_um_johnson_checker_if dec_bus ();

    assign dec_bus.code = ui_in;

    johnson_decode u_dec (
        .bus (dec_bus.slave)
    );

    logic sample_en;
    logic unused_ok;

    assign sample_en = uio_in[0];
    assign unused_ok = &{1'b0, ena, uio_in[7:1]};

    chk_state_t       state_q;
    chk_state_t       state_d;
    logic [IDX_W-1:0] prev_q;
    logic [IDX_W-1:0] index_q;
    logic             valid_q;
    logic             locked_q;
    logic             pulse_q;
    logic             sticky_q;
    logic             in_seq;
    logic             err_evt;

    // 4-bit compare so 15 -> 0 is a legal step.
    assign in_seq = dec_bus.valid &&
                    (dec_bus.index == IDX_W'(prev_q + 4'd1));

    always_comb begin
        state_d = state_q;
        err_evt = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (dec_bus.valid)
                    state_d = CHECK1;
            end
            CHECK1: begin
                if (in_seq)
                    state_d = LOCKED;
                else if (dec_bus.valid)
                    state_d = CHECK1;
                else
                    state_d = HUNT;
            end
            LOCKED: begin
                if (!in_seq) begin
                    state_d = HUNT;
                    err_evt = 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            prev_q   <= '0;
            index_q  <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            pulse_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else if (sample_en) begin
            state_q  <= state_d;
            index_q  <= dec_bus.index;
            valid_q  <= dec_bus.valid;
            locked_q <= (state_d == LOCKED);
            pulse_q  <= err_evt;
            if (dec_bus.valid)
                prev_q <= dec_bus.index;
            if (err_evt)
                sticky_q <= 1'b1;
        end else begin
            pulse_q <= 1'b0;
        end
    end

    always_comb begin
        uo_out                                 = '0;
        uo_out[UO_INDEX_LSB +: IDX_W]          = index_q;
        uo_out[UO_VALID]                       = valid_q;
        uo_out[UO_LOCKED]                      = locked_q;
        uo_out[UO_PULSE]                       = pulse_q;
        uo_out[UO_STICKY]                      = sticky_q;
    end

`ifdef JOHNSON_CHK_ERRCNT_EN
    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (sample_en && err_evt && (cnt_q != 4'hF))
            cnt_q <= cnt_q + 4'd1;
    end

    assign uio_out = {4'h0, cnt_q};
    assign uio_oe  = 8'h0F;
`else
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_tt_um_johnson_checker.sv
// Randomised scoreboard bench for tt_um_johnson_checker.
// Expected outputs come from a table-driven reference model.
module tb_tt_um_johnson_checker;
    import johnson_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena   = 1'b1;
    logic [7:0] uio_in = 8'h00;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    tt_um_johnson_checker_if bus ();

    johnson_decode u_ref_dec (
        .bus (bus.slave)
    );

    tt_um_johnson_checker dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (bus.code),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

`ifdef JOHNSON_CHK_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic [7:0] exp_oe;
    assign exp_oe = CNT_EN ? 8'h0F : 8'h00;

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uio;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] codes[16];
    bit m_locked, m_have, m_sticky, m_pulse, m_valid;
    int m_prev, m_idx, m_errs;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [7:0] c);
        for (int k = 0; k < 16; k++)
            if (codes[k] == c) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_have = 0; m_sticky = 0;
        m_pulse = 0; m_valid = 0;
        m_prev = 0; m_idx = 0; m_errs = 0;
    endtask

    task automatic sample(input logic [7:0] c, input bit en);
        int i;
        bit v, succ;
        exp_t e;
        @(negedge clk);
        bus.code = c;
        uio_in = {7'($urandom), en};
        i = lookup(c);
        v = (i >= 0);
        m_pulse = 0;
        if (en) begin
            succ = v && (i == (m_prev + 1) % 16);
            if (m_locked) begin
                if (!succ) begin
                    m_locked = 0; m_have = 0;
                    m_pulse = 1; m_sticky = 1;
                    if (m_errs < 15) m_errs++;
                end
            end else if (!v) begin
                m_have = 0;
            end else if (m_have && succ) begin
                m_locked = 1;
            end else begin
                m_have = 1;
            end
            if (v) m_prev = i;
            m_valid = v;
            m_idx = v ? i : 0;
        end
        e.uo  = {m_sticky, m_pulse, m_locked, m_valid, 4'(m_idx)};
        e.uio = CNT_EN ? 8'(m_errs) : 8'h00;
        sb.push_back(e);
        #1;
        check("ref_decode", {3'b0, bus.valid, bus.index},
              {3'b0, v, v ? 4'(i) : 4'h0});
    endtask

    task automatic wait_drain();
        int budget;
        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
            sb.delete();
        end
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("uo_out", uo_out, e.uo);
            check("uio_out", uio_out, e.uio);
            check("uio_oe", uio_oe, exp_oe);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, base;
        for (int k = 0; k < 16; k++) begin
            if (k <= 8) codes[k] = 8'((1 << k) - 1);
            else        codes[k] = 8'((255 << (k - 8)) & 255);
        end
        model_reset();
        bus.code = 8'h00;
        uio_in   = 8'h00;

        repeat (3) @(negedge clk);
        check("reset_uo", uo_out, 8'h00);
        check("reset_uio", uio_out, 8'h00);
        check("reset_oe", uio_oe, exp_oe);
        rst_n = 1'b1;

        sample(8'h00, 1);
        sample(8'h01, 1);
        sample(8'h03, 1);
        sample(8'h07, 1);

        for (int i = 0; i < 32; i++)
            sample(codes[(4 + i) % 16], 1);

        for (int i = 4; i <= 18; i++)
            sample(codes[i % 16], 1);
        sample(8'h05, 1);

        sample(codes[15], 1);
        sample(8'h00, 1);
        sample(8'h03, 1);
        sample(8'h07, 1);
        sample(8'h0F, 1);
        sample(8'h1F, 1);

        repeat (5) sample(8'($urandom), 0);

        for (int e = 0; e < 17; e++) begin
            base = int'($urandom_range(15));
            sample(codes[base], 1);
            sample(codes[(base + 1) % 16], 1);
            case (e % 3)
                0:       sample(8'h05, 1);
                1:       sample(codes[(base + 1) % 16], 1);
                default: sample(codes[base], 1);
            endcase
        end

        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(99));
            if (r < 60)
                sample(codes[(m_prev + 1) % 16], 1);
            else if (r < 75)
                sample(codes[$urandom_range(15)], 1);
            else if (r < 90)
                sample(8'($urandom), 1);
            else
                sample(8'($urandom), 0);
        end

        for (int i = 0; i < 4; i++)
            sample(codes[i], 1);
        wait_drain();

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midlock_rst_uo", uo_out, 8'h00);
        check("midlock_rst_uio", uio_out, 8'h00);
        check("midlock_rst_oe", uio_oe, exp_oe);
        uio_in = 8'h00;
        repeat (2) @(negedge clk);
        check("held_rst_uo", uo_out, 8'h00);
        rst_n = 1'b1;
        model_reset();

        sample(codes[5], 1);
        sample(codes[6], 1);
        sample(codes[7], 1);
        sample(8'h55, 1);
        sample(codes[0], 0);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
